sng_burst_sched: RTL and testbench
==================================

Name: sng_burst_sched

Overview:
- Sequences quantized weight bursts into the stochastic-number-generator datapath.
- Buffers incoming weights in a small FIFO and hands them to the SNG with a valid/ready handshake.
- Owns the 2-bit phase index that drives the SNG phase-rotation stage; the phase restarts at every burst boundary (last).
- Isolates bursts: a new burst is not accepted until the previous burst's last weight has been consumed. Reports burst completion and length.

Parameters:
- QUANT, 8, weight width in bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PHASES, 4, phase modulus; power of two; PW = log2(PHASES).
- MAX_BURST, 255, saturation value of the burst length counter; LW = clog2(MAX_BURST+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; clears FIFO, FSM and counters.
- s_data  in  QUANT  incoming weight.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final weight of a burst.
- s_ready  out  1  scheduler accepts a weight.
- m_data  out  QUANT  weight presented to the SNG.
- m_valid  out  1  m_data valid; drives the SNG write-valid.
- m_last  out  1  m_data is the burst's final weight.
- m_phase  out  PW  phase index for the SNG phase stage.
- m_ready  in  1  SNG consumes m_data; driven by the SNG read-ready.
- burst_done  out  1  one-cycle pulse after the last weight is consumed.
- burst_len  out  LW  weights consumed in the current or most recent burst.
- busy  out  1  a burst is in progress (state != IDLE).

Behaviour:
- Reset (rst=1, async): FIFO empty, state IDLE. All outputs are 0: s_ready, m_valid, m_data, m_last, m_phase, burst_done, burst_len, busy. s_ready rises in the first cycle after reset deasserts.
- Handshakes:
  - Input handshake: s_valid & s_ready.
  - Output handshake: m_valid & m_ready.
  - s_ready, m_valid, m_data and m_last depend only on registers. There is no combinational path from m_ready to s_ready.
- FIFO:
  - Storage is {last, data}, DEPTH entries. m_valid = !empty. m_data and m_last present the head entry.
  - Latency: a weight accepted in cycle N is visible on m_data in cycle N+1 at the earliest.
  - A push and a pop in the same cycle keep the count unchanged. Push on full or pop on empty never occurs.
- FSM:
  - IDLE: s_ready = !full. On input handshake go to ACTIVE. If that word has s_last=1, go directly to CLOSE.
  - ACTIVE: s_ready = !full. On input handshake with s_last=1, go to CLOSE.
  - CLOSE: s_ready = 0. On output handshake with m_last=1, go to IDLE; the FIFO is empty at that point.
- Phase (m_phase):
  - Increments modulo PHASES on each output handshake with m_last=0.
  - Returns to 0 on an output handshake with m_last=1.
  - Holds otherwise.
- Burst length (burst_len):
  - Set to 1 on the first output handshake of a burst; increments on each later handshake of that burst.
  - Saturates at MAX_BURST; the excess words are still forwarded.
  - Holds its final value after the burst ends, until the next burst's first output handshake.
- burst_done: registered. High for exactly one cycle, the cycle after the output handshake with m_last=1.
- flush:
  - Priority over push and pop in the same cycle; the words offered in that cycle are dropped.
  - Next cycle: FIFO empty, state IDLE, m_phase=0, burst_len=0, burst_done=0. s_ready is 0 during the flush cycle.
- Reset mid-burst behaves as a flush, but asynchronously.
- No back-pressure deadlock: in CLOSE the FIFO always holds the last word, so it drains whenever m_ready is high.

Test Plan:
1. Reset, then burst of 3 (0x10, 0x20, 0x30 with last on 0x30), m_ready=1 → m_data 0x10/0x20/0x30 in consecutive cycles from cycle+1; m_phase 0,1,2; burst_done pulses the cycle after 0x30; burst_len=3; busy falls with burst_done.
2. Burst of 6 with m_ready=1 → m_phase sequence 0,1,2,3,0,1; the next burst's first word shows m_phase=0.
3. Push 5 words with m_ready=0, DEPTH=4 → s_ready drops after the 4th accepted word; raising m_ready drains 0x.. in order with no loss or duplication.
4. Burst of 2 ends with last; the next burst's s_valid is held high immediately → s_ready=0 until the previous last is consumed; the new first word is accepted the cycle after.
5. Assert flush mid-burst with 3 words queued → next cycle m_valid=0, m_phase=0, burst_len=0, state IDLE, no burst_done; a subsequent burst behaves as in case 1.
6. Assert rst asynchronously mid-transfer → all outputs 0 immediately; after release, a 300-word burst gives burst_len=255 (saturated) and all 300 words are forwarded.

Source files
------------

// File: rtl/sng_burst_sched.sv
// Burst scheduler feeding weights to the SNG; 1-cycle accept-to-present latency through a small FIFO.
// Backpressure: s_ready is registered and drops when full or while a closed burst drains; flush has priority.
module sng_burst_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          empty,
  output logic [CW-1:0] level_nxt
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_dat  = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign level_nxt = count_d;
endmodule

module sng_burst_sched #(
  parameter int QUANT     = 8,
  parameter int DEPTH     = 4,
  parameter int PHASES    = 4,
  parameter int MAX_BURST = 255,
  localparam int PW       = $clog2(PHASES),
  localparam int LW       = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [QUANT-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [QUANT-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic [PW-1:0]    m_phase,
  input  logic             m_ready,
  output logic             burst_done,
  output logic [LW-1:0]    burst_len,
  output logic             busy
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_CLOSE} state_t;

  state_t        state_q, state_d;
  logic          s_rdy_q, s_rdy_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [LW-1:0] len_q, len_d;
  logic          mid_q, mid_d;
  logic          done_q, done_d;

  logic          push, pop;
  logic          fifo_empty;
  logic [QUANT:0] head;
  logic [CW-1:0] level_nxt;

  assign s_ready = s_rdy_q & ~flush;
  assign m_valid = ~fifo_empty;
  assign m_data  = m_valid ? head[QUANT-1:0] : '0;
  assign m_last  = m_valid & head[QUANT];
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  sng_burst_fifo #(
    .W     (QUANT + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_dat  ({s_last, s_data}),
    .pop       (pop),
    .head_dat  (head),
    .empty     (fifo_empty),
    .level_nxt (level_nxt)
  );

  always_comb begin
    state_d = state_q;
    s_rdy_d = s_rdy_q;
    phase_d = phase_q;
    len_d   = len_q;
    mid_d   = mid_q;
    done_d  = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      s_rdy_d = 1'b1;
      phase_d = '0;
      len_d   = '0;
      mid_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE:   if (push) state_d = s_last ? S_CLOSE : S_ACTIVE;
        S_ACTIVE: if (push && s_last) state_d = S_CLOSE;
        S_CLOSE:  if (pop && m_last) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
      if (pop) begin
        phase_d = m_last ? '0 : phase_q + PW'(1);
        // mid_q marks that this burst already produced its first output word.
        if (!mid_q)                         len_d = LW'(1);
        else if (len_q != LW'(MAX_BURST))   len_d = len_q + LW'(1);
        mid_d  = ~m_last;
        done_d = m_last;
      end
      // Look ahead at next state/level so s_ready stays a pure flop output.
      s_rdy_d = (state_d != S_CLOSE) && (level_nxt != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      s_rdy_q <= 1'b0;
      phase_q <= '0;
      len_q   <= '0;
      mid_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_rdy_q <= s_rdy_d;
      phase_q <= phase_d;
      len_q   <= len_d;
      mid_q   <= mid_d;
      done_q  <= done_d;
    end
  end

  assign m_phase    = phase_q;
  assign burst_len  = len_q;
  assign burst_done = done_q;
  assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_sng_burst_sched.sv
// Bench for sng_burst_sched: directed bursts plus an output scoreboard with phase/length/done model.
module tb_sng_burst_sched;
  logic       clk, rst, flush;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_ready;
  logic [7:0] m_data;
  logic       m_valid, m_last, m_ready;
  logic [1:0] m_phase;
  logic       burst_done, busy;
  logic [7:0] burst_len;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  logic [8:0] sb [$];
  logic [8:0] exp_word;
  logic [1:0] exp_phase;
  logic [7:0] exp_len;
  logic       exp_mid, exp_done, nxt_done;

  sng_burst_sched dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_phase    (m_phase),
    .m_ready    (m_ready),
    .burst_done (burst_done),
    .burst_len  (burst_len),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Scoreboard and reference model, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_phase = '0;
      exp_len   = '0;
      exp_mid   = 1'b0;
      exp_done  = 1'b0;
    end
    total++;
    if (m_phase !== exp_phase) begin
      bad++;
      $display("FAIL phase @%0t: got %0d want %0d", $time, m_phase, exp_phase);
    end
    total++;
    if (burst_len !== exp_len) begin
      bad++;
      $display("FAIL burst_len @%0t: got %0d want %0d", $time, burst_len, exp_len);
    end
    total++;
    if (burst_done !== exp_done) begin
      bad++;
      $display("FAIL burst_done @%0t: got %0b want %0b", $time, burst_done, exp_done);
    end
    if (!rst && flush) begin
      sb.delete();
      exp_phase = '0;
      exp_len   = '0;
      exp_mid   = 1'b0;
      exp_done  = 1'b0;
    end else if (!rst) begin
      nxt_done = 1'b0;
      if (m_valid && m_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL out_word @%0t: got %h want none", $time, {m_last, m_data});
        end else begin
          exp_word = sb.pop_front();
          if ({m_last, m_data} !== exp_word) begin
            bad++;
            $display("FAIL out_word @%0t: got %h want %h", $time, {m_last, m_data}, exp_word);
          end
        end
        n_out++;
        exp_len   = !exp_mid ? 8'd1 : (exp_len == 8'd255 ? exp_len : exp_len + 8'd1);
        exp_mid   = !m_last;
        exp_phase = m_last ? 2'd0 : exp_phase + 2'd1;
        nxt_done  = m_last;
      end
      exp_done = nxt_done;
      if (s_valid && s_ready) sb.push_back({s_last, s_data});
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Offer one word from posedge+1 and return at posedge+1 after it is accepted.
  task automatic send(input logic [7:0] d, input logic l);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_accept: got s_ready=0 for 200 cycles want accept of %h", d);
    end
    sync();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (burst_done) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL burst_done_wait: got no pulse in 50 cycles want pulse");
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({s_ready, m_valid, m_data, m_last, m_phase, burst_done, burst_len, busy} !== 23'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {s_ready, m_valid, m_data, m_last, m_phase, burst_done, burst_len, busy});
    end
    sync();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({s_ready, m_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL reset_release: got s_ready/m_valid/busy=%b want 100", {s_ready, m_valid, busy});
    end
  endtask

  task automatic test_burst3();
    sync();
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'h10; s_last = 1'b0;
    @(negedge clk);
    total++;
    if ({s_ready, m_valid} !== 2'b10) begin
      bad++; $display("FAIL b3_start: got s_ready/m_valid=%b want 10", {s_ready, m_valid});
    end
    sync(); s_data = 8'h20;
    @(negedge clk);
    total++;
    if ({m_valid, m_data} !== {1'b1, 8'h10}) begin
      bad++; $display("FAIL b3_word0: got %h want 110", {m_valid, m_data});
    end
    sync(); s_data = 8'h30; s_last = 1'b1;
    @(negedge clk);
    total++;
    if ({m_valid, m_data} !== {1'b1, 8'h20}) begin
      bad++; $display("FAIL b3_word1: got %h want 120", {m_valid, m_data});
    end
    sync(); s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    total++;
    if ({m_valid, m_last, m_data, busy, burst_done} !== {2'b11, 8'h30, 2'b10}) begin
      bad++; $display("FAIL b3_word2: got %h want %h", {m_valid, m_last, m_data, busy, burst_done},
                      {2'b11, 8'h30, 2'b10});
    end
    @(negedge clk);
    total++;
    if ({burst_done, busy, m_valid, burst_len} !== {3'b100, 8'd3}) begin
      bad++; $display("FAIL b3_done: got %h want %h", {burst_done, busy, m_valid, burst_len}, {3'b100, 8'd3});
    end
    @(negedge clk);
    total++;
    if (burst_done !== 1'b0) begin
      bad++; $display("FAIL b3_done_pulse: got %b want 0", burst_done);
    end
  endtask

  task automatic test_phase_wrap();
    sync();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(8'h60 + 8'(i), i == 5);
    wait_done();
    total++;
    if (burst_len !== 8'd6) begin
      bad++; $display("FAIL b6_len: got %0d want 6", burst_len);
    end
    sync();
    send(8'h6a, 1'b1);
    wait_done();
    total++;
    if ({burst_len, m_phase} !== {8'd1, 2'd0}) begin
      bad++; $display("FAIL b1_len_phase: got %h want 100", {burst_len, m_phase});
    end
  endtask

  task automatic test_fill();
    int n0;
    sync();
    m_ready = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), 1'b0);
    @(negedge clk);
    total++;
    if ({s_ready, m_valid, m_data} !== {2'b01, 8'h41}) begin
      bad++; $display("FAIL fill_full: got %h want %h", {s_ready, m_valid, m_data}, {2'b01, 8'h41});
    end
    sync();
    m_ready = 1'b1;
    send(8'h45, 1'b1);
    wait_done();
    total++;
    if (burst_len !== 8'd5 || n_out - n0 !== 5 || sb.size() !== 0) begin
      bad++; $display("FAIL fill_drain: got len=%0d out=%0d left=%0d want 5 5 0", burst_len, n_out - n0, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    sync();
    m_ready = 1'b0;
    send(8'h51, 1'b0);
    send(8'h52, 1'b1);
    s_valid = 1'b1; s_data = 8'h61; s_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (s_ready !== 1'b0) begin
        bad++; $display("FAIL b2b_blocked: got s_ready=%b want 0", s_ready);
      end
    end
    sync();
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid && m_last) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || s_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_last: got seen=%b s_ready=%b want 1 0", seen, s_ready);
    end
    @(negedge clk);
    total++;
    if ({s_ready, burst_done, busy} !== 3'b110) begin
      bad++; $display("FAIL b2b_reopen: got %b want 110", {s_ready, burst_done, busy});
    end
    sync();
    s_valid = 1'b0; s_last = 1'b0;
    wait_done();
    total++;
    if (burst_len !== 8'd1) begin
      bad++; $display("FAIL b2b_len: got %0d want 1", burst_len);
    end
  endtask

  task automatic test_flush();
    sync();
    m_ready = 1'b1;
    send(8'h70, 1'b0);
    send(8'h71, 1'b0);
    m_ready = 1'b0;
    send(8'h72, 1'b0);
    send(8'h73, 1'b0);
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h74; m_ready = 1'b1;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b0) begin
      bad++; $display("FAIL flush_sready: got %b want 0", s_ready);
    end
    sync();
    flush = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({m_valid, m_phase, burst_len, busy, burst_done} !== 13'd0) begin
      bad++; $display("FAIL flush_state: got %h want 0", {m_valid, m_phase, burst_len, busy, burst_done});
    end
    @(negedge clk);
    total++;
    if ({burst_done, s_ready} !== 2'b01) begin
      bad++; $display("FAIL flush_after: got %b want 01", {burst_done, s_ready});
    end
    sync();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    wait_done();
    total++;
    if (burst_len !== 8'd3) begin
      bad++; $display("FAIL flush_next_len: got %0d want 3", burst_len);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    sync();
    m_ready = 1'b1;
    send(8'h81, 1'b0);
    send(8'h82, 1'b0);
    send(8'h83, 1'b0);
    m_ready = 1'b0;
    send(8'h84, 1'b0);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({s_ready, m_valid, m_data, m_last, m_phase, burst_done, burst_len, busy} !== 23'd0) begin
      bad++;
      $display("FAIL async_reset: got %h want 0",
               {s_ready, m_valid, m_data, m_last, m_phase, burst_done, burst_len, busy});
    end
    sync();
    rst = 1'b0;
    @(negedge clk);
    sync();
    m_ready = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 300; i++) send(8'(i), i == 299);
    wait_done();
    total++;
    if (burst_len !== 8'd255 || n_out - n0 !== 300) begin
      bad++; $display("FAIL saturate: got len=%0d out=%0d want 255 300", burst_len, n_out - n0);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_burst3();
    test_phase_wrap();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    @(negedge clk);
    total++;
    if (sb.size() !== 0) begin
      bad++; $display("FAIL scoreboard_left: got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
